// File: rtl/tiny_fir_pkg.sv
// Shared types and constants for the FIR coefficient loader: FSM state
// encoding, timeout counter width and a width helper for index ports.
package tiny_fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_WAIT_RDY,
    ST_FETCH,
    ST_PRESENT,
    ST_WAIT_DONE,
    ST_RUN,
    ST_ERROR
  } fir_state_t;

  // Wide enough for any practical done-timeout setting.
  localparam int TO_CNT_W = 16;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int fn_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tiny_fir_coef_bank.sv
// Coefficient storage: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module tiny_fir_coef_bank #(
  parameter int G_DEPTH  = 32,
  parameter int G_WIDTH  = 16,
  parameter int G_ADDR_W = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [G_ADDR_W-1:0] wr_addr,
  input  logic [G_WIDTH-1:0]  wr_data,
  input  logic                rd_en,
  input  logic [G_ADDR_W-1:0] rd_addr,
  output logic [G_WIDTH-1:0]  rd_data
);

  logic [G_WIDTH-1:0] mem [G_DEPTH];

  // No reset: contents survive reset, and the read register holds its
  // value between reads so the presented tap stays stable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tiny_fir_cfg_ctrl.sv
// Loads a stored coefficient set into a FIR tap-by-tap, then gates the
// sample stream through to the FIR only while it is programmed and running.
module tiny_fir_cfg_ctrl
  import tiny_fir_pkg::*;
#(
  parameter int G_NUM_TAPS     = 16,
  parameter int G_TAP_WIDTH    = 16,
  parameter int G_DATA_WIDTH   = 16,
  parameter int G_NUM_BANKS    = 2,
  parameter int G_DONE_TIMEOUT = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_wr_en,
  input  logic [fn_width(G_NUM_BANKS)-1:0]   cfg_wr_bank,
  input  logic [fn_width(G_NUM_TAPS)-1:0]    cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]             cfg_wr_data,
  output logic                               cfg_wr_err,
  input  logic                               load_req,
  input  logic [fn_width(G_NUM_BANKS)-1:0]   load_bank,
  output logic                               busy,
  output logic                               loaded,
  output logic                               load_err,
  output logic [fn_width(G_NUM_BANKS)-1:0]   active_bank,
  output logic                               fir_enable,
  output logic [G_TAP_WIDTH-1:0]             fir_tap_dout,
  output logic                               fir_tap_valid,
  input  logic                               fir_tap_ready,
  input  logic                               fir_tap_done,
  input  logic [G_DATA_WIDTH-1:0]            s_din,
  input  logic                               s_din_valid,
  output logic                               s_din_ready,
  output logic [G_DATA_WIDTH-1:0]            fir_din,
  output logic                               fir_din_valid,
  input  logic                               fir_din_ready
);

  localparam int BW    = fn_width(G_NUM_BANKS);
  localparam int KW    = fn_width(G_NUM_TAPS);
  localparam int DEPTH = G_NUM_BANKS * G_NUM_TAPS;
  localparam int AW    = fn_width(DEPTH);

  fir_state_t          state_reg, state_next;
  logic [BW-1:0]       bank_reg, bank_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [TO_CNT_W-1:0] to_cnt_reg, to_cnt_next;
  logic                load_err_reg, load_err_next;
  logic [BW-1:0]       active_bank_reg, active_bank_next;
  logic                cfg_wr_err_reg;

  logic          load_bank_ok;
  logic          wr_bank_ok;
  logic          start_load;
  logic          wr_drop;
  logic          mem_wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr_flat;
  logic [AW-1:0] rd_addr_flat;
  logic          run;

  assign load_bank_ok = int'(load_bank) < G_NUM_BANKS;
  assign wr_bank_ok   = int'(cfg_wr_bank) < G_NUM_BANKS;
  assign start_load   = load_req && load_bank_ok;

  // The bank being streamed to the FIR is write-protected for the whole load.
  assign wr_drop   = cfg_wr_en && (!wr_bank_ok || (busy && (cfg_wr_bank == bank_reg)));
  assign mem_wr_en = cfg_wr_en && !wr_drop;

  assign wr_addr_flat = AW'(int'(cfg_wr_bank) * G_NUM_TAPS + int'(cfg_wr_addr));
  assign rd_addr_flat = AW'(int'(bank_reg) * G_NUM_TAPS + int'(k_reg));

  tiny_fir_coef_bank #(
    .G_DEPTH  (DEPTH),
    .G_WIDTH  (G_TAP_WIDTH),
    .G_ADDR_W (AW)
  ) u_coef_bank (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_addr_flat),
    .wr_data (cfg_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_flat),
    .rd_data (fir_tap_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      bank_reg        <= '0;
      k_reg           <= '0;
      to_cnt_reg      <= '0;
      load_err_reg    <= 1'b0;
      active_bank_reg <= '0;
      cfg_wr_err_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bank_reg        <= bank_next;
      k_reg           <= k_next;
      to_cnt_reg      <= to_cnt_next;
      load_err_reg    <= load_err_next;
      active_bank_reg <= active_bank_next;
      cfg_wr_err_reg  <= wr_drop;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bank_next        = bank_reg;
    k_next           = k_reg;
    to_cnt_next      = to_cnt_reg;
    load_err_next    = load_err_reg;
    active_bank_next = active_bank_reg;
    fir_enable       = 1'b1;
    fir_tap_valid    = 1'b0;
    busy             = 1'b0;
    loaded           = 1'b0;
    rd_en            = 1'b0;

    case (state_reg)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        fir_enable = (state_reg == ST_RUN);
        loaded     = (state_reg == ST_RUN);
        if (start_load) begin
          state_next    = ST_DISABLE;
          bank_next     = load_bank;
          k_next        = '0;
          load_err_next = 1'b0;
        end
      end
      ST_DISABLE: begin
        // One cycle with the FIR disabled forces it to re-initialise.
        fir_enable = 1'b0;
        busy       = 1'b1;
        state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        busy = 1'b1;
        if (fir_tap_ready) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        busy          = 1'b1;
        fir_tap_valid = 1'b1;
        if (fir_tap_ready) begin
          if (k_reg == KW'(G_NUM_TAPS - 1)) begin
            state_next  = ST_WAIT_DONE;
            to_cnt_next = '0;
          end else begin
            k_next     = k_reg + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_WAIT_DONE: begin
        busy = 1'b1;
        if (fir_tap_done) begin
          state_next       = ST_RUN;
          active_bank_next = bank_reg;
        end else if (to_cnt_reg == TO_CNT_W'(G_DONE_TIMEOUT - 1)) begin
          state_next    = ST_ERROR;
          load_err_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        fir_enable = 1'b0;
      end
    endcase
  end

  assign run           = (state_reg == ST_RUN);
  assign fir_din       = s_din;
  assign fir_din_valid = run && s_din_valid;
  assign s_din_ready   = run && fir_din_ready;

  assign load_err    = load_err_reg;
  assign active_bank = active_bank_reg;
  assign cfg_wr_err  = cfg_wr_err_reg;

endmodule

// File: tb/tb_tiny_fir_cfg_ctrl.sv
// Directed-plus-random bench for tiny_fir_cfg_ctrl: a coefficient array and
// FIR handshake model in the bench predict every tap, flag and passthrough.
module tb_tiny_fir_cfg_ctrl;

  localparam int NT = 16;
  localparam int TW = 16;
  localparam int DW = 16;
  localparam int NB = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [0:0]    cfg_wr_bank = '0;
  logic [3:0]    cfg_wr_addr = '0;
  logic [TW-1:0] cfg_wr_data = '0;
  logic          cfg_wr_err;
  logic          load_req = 1'b0;
  logic [0:0]    load_bank = '0;
  logic          busy, loaded, load_err;
  logic [0:0]    active_bank;
  logic          fir_enable;
  logic [TW-1:0] fir_tap_dout;
  logic          fir_tap_valid;
  logic          fir_tap_ready = 1'b0;
  logic          fir_tap_done = 1'b0;
  logic [DW-1:0] s_din = '0;
  logic          s_din_valid = 1'b0;
  logic          s_din_ready;
  logic [DW-1:0] fir_din;
  logic          fir_din_valid;
  logic          fir_din_ready = 1'b0;

  always #5 clk = ~clk;

  tiny_fir_cfg_ctrl #(
    .G_NUM_TAPS(NT), .G_TAP_WIDTH(TW), .G_DATA_WIDTH(DW),
    .G_NUM_BANKS(NB), .G_DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_bank(cfg_wr_bank), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_err(cfg_wr_err),
    .load_req(load_req), .load_bank(load_bank), .busy(busy), .loaded(loaded),
    .load_err(load_err), .active_bank(active_bank),
    .fir_enable(fir_enable), .fir_tap_dout(fir_tap_dout), .fir_tap_valid(fir_tap_valid),
    .fir_tap_ready(fir_tap_ready), .fir_tap_done(fir_tap_done),
    .s_din(s_din), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .fir_din(fir_din), .fir_din_valid(fir_din_valid), .fir_din_ready(fir_din_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [TW-1:0] coef [NB][NT];
  logic [0:0]    exp_active = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_fir_enable"}, fir_enable, 0);
    chk({p, "_tap_valid"}, fir_tap_valid, 0);
    chk({p, "_fir_din_valid"}, fir_din_valid, 0);
    chk({p, "_s_din_ready"}, s_din_ready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_loaded"}, loaded, 0);
    chk({p, "_load_err"}, load_err, 0);
    chk({p, "_cfg_wr_err"}, cfg_wr_err, 0);
    chk({p, "_active_bank"}, active_bank, 0);
  endtask

  task automatic cfg_write(input logic [0:0] b, input logic [3:0] a, input logic [TW-1:0] d,
                           input logic exp_err);
    cfg_wr_en = 1'b1; cfg_wr_bank = b; cfg_wr_addr = a; cfg_wr_data = d;
    tick();
    cfg_wr_en = 1'b0;
    settle();
    chk("cfg_wr_err", cfg_wr_err, exp_err);
    if (!exp_err) coef[b][a] = d;
  endtask

  task automatic passthru(input int n, input bit exp_run);
    for (int i = 0; i < n; i++) begin
      s_din = DW'($urandom);
      s_din_valid = 1'($urandom_range(0, 1));
      fir_din_ready = 1'($urandom_range(0, 1));
      settle();
      if (exp_run) begin
        chk("pt_data", fir_din, s_din);
        chk("pt_valid", fir_din_valid, s_din_valid);
        chk("pt_ready", s_din_ready, fir_din_ready);
      end else begin
        chk("gate_valid", fir_din_valid, 0);
        chk("gate_ready", s_din_ready, 0);
      end
      tick();
    end
    s_din_valid = 1'b1;
    fir_din_ready = 1'b1;
  endtask

  // One load as seen by an FIR that accepts taps with random readiness.
  task automatic run_load(input logic [0:0] b, input int stall_tap, input int stall_len,
                          input bit send_done, input int done_dly, input int abort_tap,
                          input bit wp, input bit ign);
    int got = 0;
    int cyc = 0;
    int stall_left = stall_len;
    int wp_ph = 0;
    bit prev_acc = 0;
    bit ign_done = 0;
    bit aborted = 0;
    bit rdy;
    load_bank = b; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    settle();
    chk("dis_enable", fir_enable, 0);
    chk("dis_busy", busy, 1);
    chk("dis_load_err", load_err, 0);
    chk("dis_sready", s_din_ready, 0);
    tick();
    while (got < NT && cyc < 2000 && !aborted) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (got == stall_tap && stall_left > 0) rdy = 0;
      fir_tap_ready = rdy;
      load_req = 1'b0;
      if (ign && got == 4 && !ign_done) begin
        load_req = 1'b1; load_bank = ~b; ign_done = 1;
      end
      cfg_wr_en = 1'b0;
      if (wp_ph == 1) begin
        cfg_wr_en = 1'b1; cfg_wr_bank = ~b; cfg_wr_addr = 4'd5; cfg_wr_data = 16'hBEEF;
      end
      if (wp && got == 1 && wp_ph == 0) begin
        cfg_wr_en = 1'b1; cfg_wr_bank = b; cfg_wr_addr = 4'd5; cfg_wr_data = 16'hDEAD;
      end
      settle();
      if (wp_ph == 2) begin
        chk("wp_other_ok", cfg_wr_err, 0);
        coef[~b][5] = 16'hBEEF;
        wp_ph = 3;
      end
      if (wp_ph == 1) begin
        chk("wp_same_err", cfg_wr_err, 1);
        wp_ph = 2;
      end
      if (cfg_wr_en && wp_ph == 0) wp_ph = 1;
      chk("load_enable", fir_enable, 1);
      chk("load_busy", busy, 1);
      chk("load_sready", s_din_ready, 0);
      if (prev_acc) chk("tap_gap", fir_tap_valid, 0);
      prev_acc = 0;
      if (abort_tap >= 0 && got == abort_tap && fir_tap_valid) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fir_tap_ready = 1'b0;
        load_req = 1'b0;
        cfg_wr_en = 1'b0;
        settle();
        exp_active = '0;
        chk_reset_outs("abort");
        aborted = 1;
      end else begin
        if (fir_tap_valid) begin
          if (!rdy && got == stall_tap && stall_left > 0) begin
            chk("stall_dout", fir_tap_dout, coef[b][got]);
            stall_left--;
          end
          if (rdy) begin
            chk($sformatf("tap%0d", got), fir_tap_dout, coef[b][got]);
            got++;
            prev_acc = 1;
          end
        end
        tick();
        cyc++;
      end
    end
    fir_tap_ready = 1'b0;
    cfg_wr_en = 1'b0;
    load_req = 1'b0;
    if (!aborted) begin
      chk("tap_count", got, NT);
      if (stall_tap >= 0) chk("stall_cycles_left", stall_left, 0);
      if (send_done) begin
        for (int i = 0; i < done_dly; i++) begin
          settle();
          chk("wd_busy", busy, 1);
          chk("wd_valid", fir_tap_valid, 0);
          tick();
        end
        fir_tap_done = 1'b1;
        settle();
        tick();
        fir_tap_done = 1'b0;
        settle();
        exp_active = b;
        chk("done_loaded", loaded, 1);
        chk("done_busy", busy, 0);
        chk("done_active", active_bank, exp_active);
        chk("done_enable", fir_enable, 1);
        chk("done_load_err", load_err, 0);
      end else begin
        for (int i = 0; i < TO; i++) begin
          settle();
          chk("to_busy", busy, 1);
          chk("to_err_early", load_err, 0);
          tick();
        end
        settle();
        chk("to_load_err", load_err, 1);
        chk("to_enable", fir_enable, 0);
        chk("to_sready", s_din_ready, 0);
        chk("to_busy_off", busy, 0);
        chk("to_loaded", loaded, 0);
        chk("to_active", active_bank, exp_active);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    s_din_valid = 1'b1;
    fir_din_ready = 1'b1;
    repeat (3) tick();
    settle();
    chk_reset_outs("rst");
    reset = 1'b0;
    tick();
    settle();
    chk("idle_enable", fir_enable, 0);
    chk("idle_sready", s_din_ready, 0);

    for (int k = 0; k < NT; k++) begin
      cfg_write(1'b1, 4'(k), TW'(k + 1), 1'b0);
      cfg_write(1'b0, 4'(k), TW'($urandom), 1'b0);
    end
    passthru(3, 0);

    // Bank 1 with a 5-cycle stall on tap value 3 and an ignored mid-load request.
    run_load(1'b1, 2, 5, 1, $urandom_range(0, 3), -1, 0, 1);
    passthru(8, 1);

    // Reload bank 0 from RUN while probing write protection.
    run_load(1'b0, -1, 0, 1, 2, -1, 1, 0);
    passthru(5, 1);

    // Done never arrives.
    run_load(1'b1, -1, 0, 0, 0, -1, 0, 0);
    passthru(3, 0);

    // Reset while tap index 6 (value 7 position) is presented, then a clean load.
    run_load(1'b0, -1, 0, 1, 0, 6, 0, 0);
    passthru(2, 0);
    run_load(1'b0, -1, 0, 1, $urandom_range(0, 6), -1, 0, 0);
    passthru(4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_fir_cfg_ctrl.md
TINY_FIR_CFG_CTRL -- requirements
Module: tiny_fir_cfg_ctrl

Interface
REQ-001 SHALL have parameter G_NUM_TAPS, default 16, taps per coefficient set.
REQ-002 SHALL have parameter G_TAP_WIDTH, default 16, tap word width.
REQ-003 SHALL have parameter G_DATA_WIDTH, default 16, sample width.
REQ-004 SHALL have parameter G_NUM_BANKS, default 2, stored coefficient sets.
REQ-005 SHALL have parameter G_DONE_TIMEOUT, default 8, cycles to wait for FIR done.
REQ-006 SHALL have one clock and synchronous active-high reset: clk in 1 (sole clock); reset in 1 (synchronous, active-high).
REQ-007 SHALL have these coefficient-write ports:
- cfg_wr_en in 1, coefficient write strobe.
- cfg_wr_bank in clog2(G_NUM_BANKS), target bank.
- cfg_wr_addr in clog2(G_NUM_TAPS), tap index.
- cfg_wr_data in G_TAP_WIDTH, tap value.
- cfg_wr_err out 1, one-cycle pulse when a write is dropped.
REQ-008 SHALL have these load-control ports:
- load_req in 1, start-load pulse.
- load_bank in clog2(G_NUM_BANKS), bank to load.
- busy out 1, load in progress.
- loaded out 1, FIR programmed and running.
- load_err out 1, sticky timeout flag.
- active_bank out clog2(G_NUM_BANKS), last bank successfully loaded.
REQ-009 SHALL have these FIR-side ports:
- fir_enable out 1.
- fir_tap_dout out G_TAP_WIDTH.
- fir_tap_valid out 1.
- fir_tap_ready in 1.
- fir_tap_done in 1.
REQ-010 SHALL have these sample-gating ports:
- s_din in G_DATA_WIDTH; s_din_valid in 1; s_din_ready out 1.
- fir_din out G_DATA_WIDTH; fir_din_valid out 1; fir_din_ready in 1.

Function
REQ-011 SHALL implement FSM states IDLE, DISABLE, WAIT_RDY, FETCH, PRESENT, WAIT_DONE, RUN, ERROR.
REQ-012 SHALL, on load_req in IDLE, RUN or ERROR: latch load_bank, clear tap counter k and load_err, go to DISABLE.
REQ-013 SHALL ignore load_req in DISABLE, WAIT_RDY, FETCH, PRESENT and WAIT_DONE (no queueing).
REQ-014 SHALL hold fir_enable=0 for exactly one cycle in DISABLE (forces FIR re-init), then go to WAIT_RDY.
REQ-015 SHALL hold fir_enable=1 in all states except IDLE, DISABLE and ERROR.
REQ-016 SHALL leave WAIT_RDY for FETCH on the first cycle fir_tap_ready=1.
REQ-017 SHALL, in FETCH, issue a bank read of (latched bank, k), then go to PRESENT; read data is available one cycle later.
REQ-018 SHALL, in PRESENT, drive fir_tap_valid=1 with fir_tap_dout stable until fir_tap_ready=1.
REQ-019 SHALL, on accept in PRESENT: if k=G_NUM_TAPS-1 go to WAIT_DONE, else increment k and go to FETCH.
REQ-020 SHALL deliver at most one tap per two cycles, in ascending k order.
REQ-021 SHALL, in WAIT_DONE, go to RUN on fir_tap_done=1 and update active_bank.
REQ-022 SHALL, in WAIT_DONE, go to ERROR and set load_err after G_DONE_TIMEOUT cycles with no done.
REQ-023 SHALL, in RUN, pass samples through combinationally:
- fir_din=s_din.
- fir_din_valid=s_din_valid.
- s_din_ready=fir_din_ready.
REQ-024 SHALL, outside RUN, force s_din_ready=0 and fir_din_valid=0.
REQ-025 SHALL set busy=1 in DISABLE through WAIT_DONE, and loaded=1 only in RUN.
REQ-026 SHALL, on cfg_wr_en, write cfg_wr_data to (cfg_wr_bank, cfg_wr_addr).
REQ-027 SHALL, when busy=1 and cfg_wr_bank equals the latched bank, drop the write and pulse cfg_wr_err the next cycle.
REQ-028 SHALL, when a write and a bank read hit the same bank and address in the same cycle, return the old data (read-first).
REQ-029 SHALL treat cfg_wr_bank or load_bank >= G_NUM_BANKS as an error: the write is dropped with cfg_wr_err; the load_req is ignored.

Reset
REQ-030 SHALL, on reset, go to IDLE and drive these outputs:
- fir_enable=0, fir_tap_valid=0, fir_din_valid=0, s_din_ready=0.
- busy=0, loaded=0, load_err=0, cfg_wr_err=0, active_bank=0.
REQ-031 SHALL leave coefficient memory contents unaffected by reset.
REQ-032 SHALL abort a load in progress when reset is asserted mid-load; no partial tap valid is emitted after reset.

Structure
REQ-033 SHALL place the FSM state enum and a timeout-counter width constant in shared package tiny_fir_pkg.
REQ-034 SHALL implement storage as sub-module tiny_fir_coef_bank: one write port, one registered read port, depth G_NUM_BANKS*G_NUM_TAPS.

Verification
REQ-035 SHALL check normal load: write bank1 taps 1..16, load_req bank1, FIR model ready/done -> taps 1..16 in order, then loaded=1, active_bank=1.
REQ-036 SHALL check backpressure: hold fir_tap_ready=0 for 5 cycles on tap 3 -> fir_tap_dout holds value 3 with valid=1; no skip or duplicate.
REQ-037 SHALL check timeout: done never asserted -> ERROR 8 cycles after the last tap, load_err=1, fir_enable=0, s_din_ready=0.
REQ-038 SHALL check write protection: write bank0 addr5 while loading bank0 -> cfg_wr_err pulse and memory unchanged; same write to bank1 succeeds.
REQ-039 SHALL check reload from RUN: load_req bank0 -> one cycle fir_enable=0, s_din_ready=0 until the new done, then passthrough resumes.
REQ-040 SHALL check mid-load reset: reset during tap 7 -> next cycle IDLE with all outputs at reset values; a subsequent load starts from tap 0.
